to_serial_stream: RTL and testbench
===================================

Name: to_serial_stream

Overview:
- Parallel-to-digit-serial converter for VEC_LEN lanes of BW-bit words. Each lane emits its word as CYCS digits of BW/CYCS bits.
- Sits between a parallel producer and digit-serial ternary-weight compute lanes.
- Adds the following over the plain serialiser: valid/ready handshake on both sides, a one-word holding buffer for gapless streaming, downstream backpressure, selectable digit order, digit framing flags and synchronous reset.

Parameters:
- BW, 16: word width per lane. BW % CYCS must equal 0.
- CYCS, 4: digits per word, >= 1. DW = BW/CYCS.
- VEC_LEN, 27: number of lanes.
- MSB_FIRST, 0: 0 = least-significant digit first; 1 = most-significant digit first.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- vld_in  in  1  input word valid.
- rdy_in  out  1  block can accept a word this cycle.
- in  in  [VEC_LEN-1:0][BW-1:0]  parallel input words.
- vld_out  out  1  out carries a valid digit.
- rdy_out  in  1  downstream accepts the digit this cycle.
- out  out  [VEC_LEN-1:0][DW-1:0]  current digit, per lane.
- first_out  out  1  current digit is digit 0 of its word.
- last_out  out  1  current digit is digit CYCS-1 of its word.

Behaviour:
- Input accept: a word is accepted when vld_in && rdy_in. Stages are a hold register (hold_full) and a shifter (sh_vld, digit index idx, data).
- Transfer: hold_to_shift = hold_full && (!sh_vld || (last_out && rdy_out)).
- rdy_in = !reset && (!hold_full || hold_to_shift). This is combinational from rdy_out.
- Accepted words always enter the hold register. There is no bypass into the shifter.
- On hold_to_shift: the shifter loads the hold data, sh_vld becomes 1 and idx becomes 0. hold_full becomes 1 if an accept occurs in the same cycle, else 0.
- Shifter advance: when sh_vld && rdy_out && !last_out, idx increments. LSB-first shifts data right by DW; MSB-first shifts data left by DW.
- Word end: when last_out && rdy_out and the hold is empty, sh_vld clears.
- Digit select: out[i] = data[i][DW-1:0] for LSB-first, data[i][BW-1:BW-DW] for MSB-first.
- vld_out = sh_vld. first_out = sh_vld && idx==0. last_out = sh_vld && idx==CYCS-1.
- Backpressure: while vld_out && !rdy_out, out, first_out, last_out and idx hold stable. A full hold stays full and rdy_in stays 0.
- Latency: a word accepted in cycle t, with both stages empty, drives its first digit in cycle t+2.
- Throughput: with rdy_out=1 continuously and vld_in always asserted, digits are gapless across words, including CYCS=1.
- CYCS=1: idx is constant 0, and first_out and last_out both equal vld_out.
- Reset (asserted at any time, including mid-word): next cycle hold_full=0, sh_vld=0, idx=0 and data is zeroed. So vld_out=0, first_out=0, last_out=0 and out=0. rdy_in=0 while reset is high and 1 in the first cycle after release. Any partial word is discarded.
- vld_in while rdy_in=0 is ignored. The producer must hold the word.
- Out-of-range parameters (BW % CYCS != 0, CYCS < 1) are an elaboration-time error.

Test Plan:
- LSB-first ordering: BW=16, CYCS=4, lane0=0x1234, lane26=0xABCD, accepted cycle t, rdy_out=1 -> lane0 digits 4,3,2,1 and lane26 D,C,B,A in cycles t+2..t+5. first_out only at t+2, last_out only at t+5, vld_out=0 at t+6.
- MSB_FIRST=1, same stimulus -> lane0 digits 1,2,3,4 and lane26 A,B,C,D in cycles t+2..t+5.
- Streaming: three words 0x1111, 0x2222, 0x3333 offered from cycle t, rdy_out=1 -> accepts at t, t+1, t+5. vld_out is high in every cycle t+2..t+13. rdy_in is low t+2..t+4 and t+6..t+8.
- Backpressure: rdy_out=0 during the second digit for 3 cycles -> out=3 (for 0x1234 LSB-first) held 4 cycles, idx does not advance, rdy_in stays 0 with the hold full. The word completes with no digit lost or repeated.
- Reset mid-word: assert reset during digit 2 of 0x1234 with the hold full -> next cycle vld_out=0 and out=0. rdy_in=1 after release. A new word 0x00F0 then emits 0,F,0,0 with no residue of the old word.
- CYCS=1, BW=8: words 0x5A, 0xC3 back-to-back -> out=0x5A at t+2 and 0xC3 at t+3, with first_out=last_out=1 both cycles.

Source files
------------

// File: rtl/to_serial_stream.sv
// to_serial_stream: parallel-to-digit-serial converter with a holding buffer, handshakes and framing flags.
module to_serial_stream #(
  parameter int BW = 16,
  parameter int CYCS = 4,
  parameter int VEC_LEN = 27,
  parameter int MSB_FIRST = 0,
  localparam int CS = CYCS < 1 ? 1 : CYCS,
  localparam int DW = BW / CS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          vld_in,
  output logic                          rdy_in,
  input  logic [VEC_LEN-1:0][BW-1:0]    in,
  output logic                          vld_out,
  input  logic                          rdy_out,
  output logic [VEC_LEN-1:0][DW-1:0]    out,
  output logic                          first_out,
  output logic                          last_out
);
  localparam int IW = CS > 1 ? $clog2(CS) : 1;
  if (CYCS < 1 || BW % CS != 0) begin : g_bad_params
    $error("to_serial_stream: CYCS must be >= 1 and divide BW");
  end
  logic hold_full, sh_vld, hold_to_shift, accept;
  logic [IW-1:0] idx;
  logic [VEC_LEN-1:0][BW-1:0] hold, data;
  assign vld_out = sh_vld;
  assign first_out = sh_vld && idx == '0;
  assign last_out = sh_vld && idx == IW'(CS - 1);
  assign hold_to_shift = hold_full && (!sh_vld || (last_out && rdy_out));
  assign rdy_in = !reset && (!hold_full || hold_to_shift);
  assign accept = vld_in && rdy_in;
  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    assign out[i] = MSB_FIRST != 0 ? data[i][BW-1 -: DW] : data[i][DW-1:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      sh_vld <= 1'b0;
      idx <= '0;
      hold <= '0;
      data <= '0;
    end else begin
      if (accept) hold <= in;
      hold_full <= accept || (hold_full && !hold_to_shift);
      if (hold_to_shift) begin
        data <= hold;
        sh_vld <= 1'b1;
        idx <= '0;
      end else if (sh_vld && rdy_out) begin
        if (last_out) sh_vld <= 1'b0;
        else begin
          idx <= idx + IW'(1);
          for (int i = 0; i < VEC_LEN; i++)
            data[i] <= MSB_FIRST != 0 ? data[i] << DW : data[i] >> DW;
        end
      end
    end
  end
endmodule

// File: tb/tb_to_serial_stream.sv
// tb_to_serial_stream: directed stimulus checked every cycle against a word/digit-count model of the serialiser.
module tb_to_serial_stream;
  localparam int L = 27;
  typedef logic [L-1:0][15:0] vec_t;
  logic clock = 1'b0, reset = 1'b1;
  logic vld_a = 1'b0, ro_a = 1'b1;
  vec_t in_a = '0;
  logic rdy_in_a, vld_out_a, first_a, last_a;
  logic [L-1:0][3:0] out_a;
  logic rdy_in_b, vld_out_b, first_b, last_b;
  logic [L-1:0][3:0] out_b;
  logic vld_c = 1'b0, ro_c = 1'b1;
  logic [1:0][7:0] in_c = '0;
  logic rdy_in_c, vld_out_c, first_c, last_c;
  logic [1:0][7:0] out_c;
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  to_serial_stream #(.BW(16), .CYCS(4), .VEC_LEN(L), .MSB_FIRST(0)) dut_a (
    .clock(clock), .reset(reset), .vld_in(vld_a), .rdy_in(rdy_in_a), .in(in_a),
    .vld_out(vld_out_a), .rdy_out(ro_a), .out(out_a), .first_out(first_a), .last_out(last_a));
  to_serial_stream #(.BW(16), .CYCS(4), .VEC_LEN(L), .MSB_FIRST(1)) dut_b (
    .clock(clock), .reset(reset), .vld_in(vld_a), .rdy_in(rdy_in_b), .in(in_a),
    .vld_out(vld_out_b), .rdy_out(ro_a), .out(out_b), .first_out(first_b), .last_out(last_b));
  to_serial_stream #(.BW(8), .CYCS(1), .VEC_LEN(2), .MSB_FIRST(0)) dut_c (
    .clock(clock), .reset(reset), .vld_in(vld_c), .rdy_in(rdy_in_c), .in(in_c),
    .vld_out(vld_out_c), .rdy_out(ro_c), .out(out_c), .first_out(first_c), .last_out(last_c));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a hold slot plus the current word and how many of its digits have gone out.
  int cy[3] = '{4, 4, 1};
  int dw[3] = '{4, 4, 8};
  int ms[3] = '{0, 1, 0};
  int nl[3] = '{L, L, 2};
  logic m_hf[3], m_v[3];
  int m_n[3];
  logic [15:0] m_hold[3][L], m_cur[3][L];

  function automatic logic vi(int k);
    return k < 2 ? vld_a : vld_c;
  endfunction
  function automatic logic ro(int k);
    return k < 2 ? ro_a : ro_c;
  endfunction
  function automatic logic [15:0] inw(int k, int i);
    return k < 2 ? in_a[i] : (i < 2 ? {8'h00, in_c[i[0]]} : 16'h0000);
  endfunction
  function automatic logic xfer(int k);
    return m_hf[k] && (!m_v[k] || (m_n[k] == cy[k] - 1 && ro(k)));
  endfunction
  function automatic logic erdy(int k);
    return !reset && (!m_hf[k] || xfer(k));
  endfunction
  function automatic int edig(int k, int i);
    int s;
    s = ms[k] != 0 ? cy[k] - 1 - m_n[k] : m_n[k];
    return int'(m_cur[k][i] >> (s * dw[k])) & ((1 << dw[k]) - 1);
  endfunction
  function automatic int ddig(int k, int i);
    return k == 0 ? int'(out_a[i]) : k == 1 ? int'(out_b[i]) : int'(out_c[i[0]]);
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      logic x, a;
      if (reset) begin
        m_hf[k] = 1'b0;
        m_v[k] = 1'b0;
        m_n[k] = 0;
      end else begin
        x = xfer(k);
        a = vi(k) && erdy(k);
        if (x) begin
          for (int i = 0; i < L; i++) m_cur[k][i] = m_hold[k][i];
          m_v[k] = 1'b1;
          m_n[k] = 0;
        end else if (m_v[k] && ro(k)) begin
          if (m_n[k] == cy[k] - 1) m_v[k] = 1'b0;
          else m_n[k]++;
        end
        if (a) for (int i = 0; i < L; i++) m_hold[k][i] = inw(k, i);
        m_hf[k] = a || (m_hf[k] && !x);
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      logic ev, ef, el;
      logic [3:0] got;
      ev = m_v[k];
      ef = ev && m_n[k] == 0;
      el = ev && m_n[k] == cy[k] - 1;
      got = k == 0 ? {rdy_in_a, vld_out_a, first_a, last_a} :
            k == 1 ? {rdy_in_b, vld_out_b, first_b, last_b} :
                     {rdy_in_c, vld_out_c, first_c, last_c};
      chk($sformatf("dut%0d rdy_in/vld/first/last", k), 64'(got), 64'({erdy(k), ev, ef, el}));
      if (ev)
        for (int i = 0; i < nl[k]; i++)
          chk($sformatf("dut%0d out lane%0d", k, i), 64'(ddig(k, i)), 64'(edig(k, i)));
    end
  end

  vec_t ws[4];
  logic [3:0] t0[20], t26[20], b0[20], b26[20];
  logic [19:0] tv, tf, tl, tr, tz;
  int acc[4];

  // Producer holds each word until accepted; per-cycle traces feed the literal checks.
  task automatic run(input int nw, input int ncyc, input int st_lo, input int st_hi, input int rst_c);
    int wi = 0;
    for (int i = 0; i < 4; i++) acc[i] = -1;
    for (int c = 0; c < ncyc; c++) begin
      ro_a = !(c >= st_lo && c < st_hi);
      reset = c == rst_c;
      vld_a = wi < nw;
      in_a = wi < nw ? ws[wi] : '0;
      #1;
      t0[c] = out_a[0];
      t26[c] = out_a[26];
      b0[c] = out_b[0];
      b26[c] = out_b[26];
      tv[c] = vld_out_a;
      tf[c] = first_a;
      tl[c] = last_a;
      tr[c] = rdy_in_a;
      tz[c] = out_a == '0 && out_b == '0;
      if (vld_a && rdy_in_a) begin
        acc[wi] = c;
        wi++;
      end
      @(posedge clock);
      #1;
    end
    vld_a = 1'b0;
    ro_a = 1'b1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset vld_out", 64'(vld_out_a), 64'(0));
    chk("reset rdy_in", 64'(rdy_in_a), 64'(0));
    chk("reset out zero", 64'(out_a == '0), 64'(1));
    reset = 1'b0;
    for (int i = 0; i < L; i++) ws[0][i] = 16'(i * 16'h0111);
    ws[0][0] = 16'h1234;
    ws[0][26] = 16'hABCD;
    run(1, 8, 99, 99, 99);
    chk("lsb accept cycle", 64'(acc[0]), 64'(0));
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("lsb lane0 digit%0d", d), 64'(t0[2+d]), 64'(4 - d));
      chk($sformatf("lsb lane26 digit%0d", d), 64'(t26[2+d]), 64'(13 - d));
      chk($sformatf("msb lane0 digit%0d", d), 64'(b0[2+d]), 64'(1 + d));
      chk($sformatf("msb lane26 digit%0d", d), 64'(b26[2+d]), 64'(10 + d));
    end
    chk("lsb first flags", 64'(tf[7:0]), 64'(8'b0000_0100));
    chk("lsb last flags", 64'(tl[7:0]), 64'(8'b0010_0000));
    chk("lsb vld after word", 64'(tv[6]), 64'(0));
    ws[0] = {L{16'h1111}};
    ws[1] = {L{16'h2222}};
    ws[2] = {L{16'h3333}};
    run(3, 16, 99, 99, 99);
    chk("stream accept0", 64'(acc[0]), 64'(0));
    chk("stream accept1", 64'(acc[1]), 64'(1));
    chk("stream accept2", 64'(acc[2]), 64'(5));
    chk("stream vld_out", 64'(tv[15:0]), 64'(16'h3FFC));
    chk("stream rdy_in", 64'(tr[15:0]), 64'(16'hFE23));
    ws[0] = {L{16'h1234}};
    ws[1] = {L{16'h5678}};
    ws[2] = {L{16'h9ABC}};
    run(3, 18, 3, 6, 99);
    begin
      logic [3:0] e[8] = '{4'h4, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2, 4'h1, 4'h8};
      for (int c = 0; c < 8; c++) chk($sformatf("bp lane0 c%0d", c + 2), 64'(t0[c+2]), 64'(e[c]));
    end
    chk("bp rdy_in low", 64'(tr[7:2]), 64'(0));
    chk("bp accept2", 64'(acc[2]), 64'(8));
    ws[0] = {L{16'h1234}};
    ws[1] = {L{16'h5678}};
    run(2, 6, 99, 99, 4);
    chk("rst digit2 before", 64'(t0[4]), 64'(2));
    chk("rst rdy_in during", 64'(tr[4]), 64'(0));
    chk("rst vld_out after", 64'(tv[5]), 64'(0));
    chk("rst out zero after", 64'(tz[5]), 64'(1));
    chk("rst rdy_in after", 64'(tr[5]), 64'(1));
    ws[0] = {L{16'h00F0}};
    run(1, 7, 99, 99, 99);
    begin
      logic [3:0] e[4] = '{4'h0, 4'hF, 4'h0, 4'h0};
      for (int d = 0; d < 4; d++) chk($sformatf("post-rst digit%0d", d), 64'(t0[d+2]), 64'(e[d]));
    end
    chk("post-rst first", 64'(tf[2]), 64'(1));
    chk("post-rst last", 64'(tl[5]), 64'(1));
    vld_c = 1'b1;
    in_c = {8'hA5, 8'h5A};
    #1;
    chk("c1 rdy_in w0", 64'(rdy_in_c), 64'(1));
    @(posedge clock);
    #1;
    in_c = {8'h3C, 8'hC3};
    #1;
    chk("c1 rdy_in w1", 64'(rdy_in_c), 64'(1));
    @(posedge clock);
    #1;
    vld_c = 1'b0;
    chk("c1 out w0", 64'(out_c), 64'(16'hA55A));
    chk("c1 flags w0", 64'({vld_out_c, first_c, last_c}), 64'(3'b111));
    @(posedge clock);
    #1;
    chk("c1 out w1", 64'(out_c), 64'(16'h3CC3));
    chk("c1 flags w1", 64'({vld_out_c, first_c, last_c}), 64'(3'b111));
    @(posedge clock);
    #1;
    chk("c1 idle", 64'(vld_out_c), 64'(0));
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
